// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: feeds (a,b) pairs to an external 8x8->16 multiplier,
// accumulates the products and presents the sum on a valid/ready output.
module dot_product_ctrl #(
  parameter int N_MAX   = 16,
  parameter int ACC_W   = 24,
  parameter int TIMEOUT = 64,
  parameter int LEN_W   = $clog2(N_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             mul_start,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic             mul_done,
  input  logic [15:0]      mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             err_timeout,
  output logic             busy
);

  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MUL,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [WD_W-1:0]  wdog;
  logic [ACC_W-1:0] acc;
  logic [SUM_W-1:0] sum_ext;
  logic [LEN_W-1:0] len_clamped;

  // One extra bit captures the carry out of the accumulator for the sticky flag.
  assign sum_ext     = {1'b0, acc} + SUM_W'(mul_result);
  assign len_clamped = (cfg_len > LEN_W'(N_MAX)) ? LEN_W'(N_MAX) : cfg_len;
  assign out_sum     = acc;

  // NOTE: every register here is updated with <= so all flops sample the
  // same pre-edge values; blocking assignments would create order-dependent
  // behaviour between the state and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len         <= '0;
      cnt         <= '0;
      wdog        <= '0;
      acc         <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      in_ready    <= 1'b0;
      mul_start   <= 1'b0;
      out_valid   <= 1'b0;
      out_ovf     <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go) begin
            len         <= len_clamped;
            acc         <= '0;
            cnt         <= '0;
            out_ovf     <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b1;
            if (len_clamped != '0) begin
              state    <= S_FETCH;
              in_ready <= 1'b1;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (in_valid) begin
            mul_a     <= in_a;
            mul_b     <= in_b;
            in_ready  <= 1'b0;
            mul_start <= 1'b1;
            wdog      <= '0;
            state     <= S_MUL;
          end
        end

        S_MUL: begin
          wdog <= wdog + 1'b1;
          if (mul_done) begin
            acc       <= sum_ext[ACC_W-1:0];
            out_ovf   <= out_ovf | sum_ext[ACC_W];
            cnt       <= cnt + 1'b1;
            mul_start <= 1'b0;
            state     <= S_GAP;
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            // The multiplier never answered: abort with the partial sum.
            err_timeout <= 1'b1;
            mul_start   <= 1'b0;
            out_valid   <= 1'b1;
            state       <= S_DONE;
          end
        end

        S_GAP: begin
          // Wait for a held done to clear so it is not counted twice.
          if (!mul_done) begin
            if (cnt == len) begin
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b0;
          mul_start <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
